piso_serializer: RTL and testbench

Parallel-in, serial-out serializer: accepts one WIDTH-bit word over a valid/ready handshake and emits it one bit per enabled clock with framing flags. It is the transmit-side counterpart of the team's serial-in/parallel-out deserializer. It sits between a word-wide producer and any single-bit serial link. It is built from the same enable-gated, synchronously reset flop style as the rest of the base component library.

---
 rtl/base_pkg.sv | 20 ++
 rtl/mod_counter.sv | 40 ++++
 rtl/piso_serializer.sv | 130 +++++++++++++
 tb/tb_piso_serializer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/base_pkg.sv
`default_nettype none
// ============================================================================
// Module   : base_pkg
// Brief    : Shared FSM state encoding and counter sizing for base components.
// Revision : 1.0
// ============================================================================
package base_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..modulus-1; never below one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Brief    : Modulo-MODULUS up-counter with enable, sync clear and terminal flag.
// Revision : 1.0
// ============================================================================
module mod_counter #(
  parameter int MODULUS = 8,
  parameter int CW      = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  localparam logic [CW-1:0] c_TERM = CW'(MODULUS - 1);

  logic [CW-1:0] r_count;

  // Out-of-range values behave as terminal so the counter always recovers.
  assign o_tc    = (r_count >= c_TERM);
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en) begin
      if (i_clr || o_tc) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Brief    : Valid/ready word input, one framed serial bit per enabled clock.
// Revision : 1.0
// ============================================================================
module piso_serializer
  import base_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_sdata,
  output logic             o_svalid,
  output logic             o_first,
  output logic             o_last
);

  localparam int              c_CW      = cnt_width(WIDTH);
  localparam logic [c_CW-1:0] c_LAST_M1 = c_CW'(WIDTH - 2);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_sdata;
  logic             r_svalid;
  logic             r_first;
  logic             r_last;
  logic [c_CW-1:0]  w_count;
  logic             w_tc;
  logic             w_ready;
  logic             w_accept;
  logic             w_cnt_clr;
  logic             w_load_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_next_rest;

  assign w_ready   = i_en && !i_rst &&
                     ((r_state == ST_IDLE) || ((r_state == ST_SHIFT) && w_tc));
  assign w_accept  = i_valid && w_ready;
  assign w_cnt_clr = w_accept || (r_state == ST_IDLE);

  mod_counter #(
    .MODULUS (WIDTH),
    .CW      (c_CW)
  ) u_bit_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_clr   (w_cnt_clr),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  // The shift register always holds the not-yet-sent bits aligned to the output end.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_load_bit  = i_data[WIDTH-1];
      assign w_load_rest = {i_data[WIDTH-2:0], 1'b0};
      assign w_next_bit  = r_shreg[WIDTH-1];
      assign w_next_rest = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_load_bit  = i_data[0];
      assign w_load_rest = {1'b0, i_data[WIDTH-1:1]};
      assign w_next_bit  = r_shreg[0];
      assign w_next_rest = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = ST_SHIFT;
    end else if ((r_state == ST_SHIFT) && w_tc) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else if (i_en) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shreg  <= '0;
      r_sdata  <= 1'b0;
      r_svalid <= 1'b0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
    end else if (i_en) begin
      if (w_accept) begin
        r_shreg  <= w_load_rest;
        r_sdata  <= w_load_bit;
        r_svalid <= 1'b1;
        r_first  <= 1'b1;
        r_last   <= 1'b0;
      end else if ((r_state == ST_SHIFT) && !w_tc) begin
        r_shreg  <= w_next_rest;
        r_sdata  <= w_next_bit;
        r_svalid <= 1'b1;
        r_first  <= 1'b0;
        r_last   <= (w_count == c_LAST_M1);
      end else begin
        r_sdata  <= 1'b0;
        r_svalid <= 1'b0;
        r_first  <= 1'b0;
        r_last   <= 1'b0;
      end
    end
  end

  assign o_ready  = w_ready;
  assign o_sdata  = r_sdata;
  assign o_svalid = r_svalid;
  assign o_first  = r_first;
  assign o_last   = r_last;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Brief    : Self-checking bench for MSB-first and LSB-first serializer builds.
// Revision : 1.0
// ============================================================================
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] data;
  logic         valid;
  logic         m_ready, m_sdata, m_svalid, m_first, m_last;
  logic         l_ready, l_sdata, l_svalid, l_first, l_last;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_valid(valid),
    .o_ready(m_ready), .o_sdata(m_sdata), .o_svalid(m_svalid),
    .o_first(m_first), .o_last(m_last)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_valid(valid),
    .o_ready(l_ready), .o_sdata(l_sdata), .o_svalid(l_svalid),
    .o_first(l_first), .o_last(l_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bit p (0 = first sent) of word w in the given bit order.
  function automatic logic ref_bit(input logic [W-1:0] w, input int p, input bit msb);
    return msb ? w[W-1-p] : w[p];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; valid = 1'b1; data = W'($urandom);
    tick(); tick();
    checks++;
    if ({m_sdata, m_svalid, m_first, m_last, m_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000", {m_sdata, m_svalid, m_first, m_last, m_ready});
    end
    rst = 1'b0; valid = 1'b0; #1;
    checks++;
    if (m_ready !== 1'b1 || m_svalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b svalid=%b required ready=1 svalid=0", m_ready, m_svalid);
    end
  endtask

  // Sends one word on both instances and checks the chosen instance's frame.
  task automatic run_frame(input logic [W-1:0] w, input bit msb, input string name);
    logic sd, sv, fi, la, rd;
    data = w; valid = 1'b1; #1;
    rd = msb ? m_ready : l_ready;
    checks++;
    if (rd !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_idle: got %b required 1", name, rd);
    end
    tick();
    valid = 1'b0; data = W'($urandom);
    for (int i = 0; i < W; i++) begin
      sd = msb ? m_sdata : l_sdata;  sv = msb ? m_svalid : l_svalid;
      fi = msb ? m_first : l_first;  la = msb ? m_last : l_last;
      checks++;
      if (sd !== ref_bit(w, i, msb) || sv !== 1'b1 || fi !== (i == 0) || la !== (i == W-1)) begin
        errors++;
        $display("FAIL %s_bit%0d: got sdata=%b svalid=%b first=%b last=%b required sdata=%b svalid=1 first=%b last=%b",
                 name, i, sd, sv, fi, la, ref_bit(w, i, msb), (i == 0), (i == W-1));
      end
      tick();
    end
    sv = msb ? m_svalid : l_svalid;
    sd = msb ? m_sdata : l_sdata;
    checks++;
    if (sv !== 1'b0 || sd !== 1'b0) begin
      errors++;
      $display("FAIL %s_frame_end: got svalid=%b sdata=%b required 0 0", name, sv, sd);
    end
  endtask

  task automatic test_single();
    run_frame(8'hA5, 1'b1, "single_a5");
  endtask

  task automatic test_lsb_first();
    run_frame(8'h01, 1'b0, "lsb_01");
  endtask

  task automatic test_back_to_back();
    data = 8'hFF; valid = 1'b1; en = 1'b1;
    tick();
    data = 8'h00;
    for (int i = 0; i < 2*W; i++) begin
      checks++;
      if (m_svalid !== 1'b1 || m_sdata !== (i < W) || m_first !== (i == 0 || i == W)) begin
        errors++;
        $display("FAIL b2b_bit%0d: got svalid=%b sdata=%b first=%b required 1 %b %b",
                 i, m_svalid, m_sdata, m_first, (i < W), (i == 0 || i == W));
      end
      if (i == W-1) begin
        checks++;
        if (m_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_last: got %b required 1", m_ready);
        end
      end
      tick();
      if (i == W-1) valid = 1'b0;
    end
    checks++;
    if (m_svalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got svalid=%b required 0", m_svalid);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] w;
    w = 8'hC3;
    data = w; valid = 1'b1; en = 1'b1;
    tick();
    valid = 1'b0;
    tick(); tick();
    en = 1'b0; #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (m_sdata !== ref_bit(w, 2, 1'b1) || m_svalid !== 1'b1 || m_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got sdata=%b svalid=%b ready=%b required %b 1 0",
                 s, m_sdata, m_svalid, m_ready, ref_bit(w, 2, 1'b1));
      end
      tick();
    end
    en = 1'b1;
    tick();
    for (int i = 3; i < W; i++) begin
      checks++;
      if (m_sdata !== ref_bit(w, i, 1'b1) || m_svalid !== 1'b1 || m_last !== (i == W-1)) begin
        errors++;
        $display("FAIL stall_bit%0d: got sdata=%b svalid=%b last=%b required %b 1 %b",
                 i, m_sdata, m_svalid, m_last, ref_bit(w, i, 1'b1), (i == W-1));
      end
      tick();
    end
    checks++;
    if (m_svalid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: got svalid=%b required 0", m_svalid);
    end
  endtask

  task automatic test_reset_midframe();
    data = 8'h5A; valid = 1'b1; en = 1'b1;
    tick();
    valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    checks++;
    if ({m_sdata, m_svalid, m_first, m_last} !== 4'b0 || m_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset: got outs=%b ready=%b required 0000 1",
               {m_sdata, m_svalid, m_first, m_last}, m_ready);
    end
    run_frame(8'h3C, 1'b1, "after_reset_3c");
  endtask

  // Position-in-frame model driven by random valid/enable/data on both builds.
  task automatic test_random();
    int           pos;
    logic [W-1:0] word;
    bit           exp_rdy, exp_sd_m, exp_sd_l;
    pos = -1; word = '0;
    for (int c = 0; c < 400; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      valid = ($urandom_range(0, 3) != 0);
      data  = W'($urandom);
      #1;
      exp_rdy = en && (pos == -1 || pos == W-1);
      checks++;
      if (m_ready !== exp_rdy || l_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready c%0d: got msb=%b lsb=%b required %b", c, m_ready, l_ready, exp_rdy);
      end
      if (en) begin
        if (valid && exp_rdy) begin
          word = data; pos = 0;
        end else if (pos >= 0) begin
          pos = (pos == W-1) ? -1 : pos + 1;
        end
      end
      tick();
      exp_sd_m = (pos >= 0) ? ref_bit(word, pos, 1'b1) : 1'b0;
      exp_sd_l = (pos >= 0) ? ref_bit(word, pos, 1'b0) : 1'b0;
      checks++;
      if (m_svalid !== (pos >= 0) || m_sdata !== exp_sd_m || m_first !== (pos == 0) ||
          m_last !== (pos == W-1) || l_svalid !== (pos >= 0) || l_sdata !== exp_sd_l ||
          l_first !== (pos == 0) || l_last !== (pos == W-1)) begin
        errors++;
        $display("FAIL rand_out c%0d: got msb=%b%b%b%b lsb=%b%b%b%b required msb=%b%b%b%b lsb=%b%b%b%b (svalid sdata first last)",
                 c, m_svalid, m_sdata, m_first, m_last, l_svalid, l_sdata, l_first, l_last,
                 (pos >= 0), exp_sd_m, (pos == 0), (pos == W-1),
                 (pos >= 0), exp_sd_l, (pos == 0), (pos == W-1));
      end
    end
    valid = 1'b0; en = 1'b1;
    for (int c = 0; c < W+2; c++) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_stall();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
